// File: rtl/dm_pkg.sv
// Shared types and helpers for the dm_responder data-memory slave.
package dm_pkg;

    localparam int DM_WORD_W = 32;
    localparam int DM_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    // True when the byte address is word aligned and inside a depth-word array.
    function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth);
        logic [63:0] limit;
        limit = {32'd0, depth} << 2;
        return (addr[1:0] == 2'b00) && (addr < limit);
    endfunction

endpackage

// File: rtl/dm_array.sv
// DEPTH x 32 storage: synchronous byte-lane write, registered read.
module dm_array
    import dm_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [3:0]                 be,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [DM_WORD_W-1:0]       wdata,
    output logic [DM_WORD_W-1:0]       rdata
);

    logic [DM_WORD_W-1:0] mem_q [DEPTH];
    logic [DM_WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder with wait states and a PC stall output.
// Optional byte-lane store enables when DM_BYTE_EN is defined.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [AW-1:0]         req_addr,
    input  logic [DM_WORD_W-1:0]  req_wdata,
`ifdef DM_BYTE_EN
    input  logic [3:0]            req_be,
`endif
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DM_WORD_W-1:0]  rsp_rdata,
    output logic                  rsp_err,
    output logic                  stall
);

    localparam int IW = $clog2(DEPTH);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("dm_responder: WAIT_CYCLES must be 0..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dm_responder: DEPTH must be a power of two");
    end
    if (AW < IW + 2) begin : g_bad_aw
        $error("dm_responder: AW too narrow for DEPTH");
    end

    dm_state_e             state_q, state_d;
    logic [DM_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DM_WORD_W-1:0]  wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [3:0]            be_in;
    logic                  go_resp;

    logic                  op_write;
    logic [AW-1:0]         op_addr;
    logic [DM_WORD_W-1:0]  op_wdata;
    logic [3:0]            op_be;
    logic                  op_ok;
    logic                  resp_ok;
    logic [DM_WORD_W-1:0]  arr_rdata;

`ifdef DM_BYTE_EN
    assign be_in = req_be;
`else
    assign be_in = 4'hF;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = be_in;
                    cnt_d   = DM_CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - DM_CNT_W'(1);
                if (cnt_q == DM_CNT_W'(1)) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // With zero wait states the array is touched on the accepting edge, so it
    // must see the live request rather than the not-yet-captured copy.
    always_comb begin
        if (state_q == IDLE) begin
            op_write = req_write;
            op_addr  = req_addr;
            op_wdata = req_wdata;
            op_be    = be_in;
        end else begin
            op_write = write_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
            op_be    = be_q;
        end
    end

    assign op_ok   = addr_ok(64'(op_addr), unsigned'(DEPTH));
    assign resp_ok = addr_ok(64'(addr_q), unsigned'(DEPTH));

    dm_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (go_resp & op_write & op_ok),
        .be    (op_be),
        .re    (go_resp & ~op_write & op_ok),
        .idx   (op_addr[IW+1:2]),
        .wdata (op_wdata),
        .rdata (arr_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) & ~resp_ok;
    assign rsp_rdata = ((state_q == RESP) & ~write_q & resp_ok) ? arr_rdata : '0;
    assign stall     = ~reset & (((state_q == IDLE) & req_valid) | (state_q == WAIT));

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: two instances (2 and 0 wait states) against a transaction-level model.
`timescale 1ns/1ps
module tb_dm_responder;

    localparam int DEPTH = 64;
    localparam int NI    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        v   [NI];
    logic        w   [NI];
    logic [31:0] a   [NI];
    logic [31:0] d   [NI];
    logic [3:0]  be  [NI];
    logic        rdy [NI];
    logic        vld [NI];
    logic        stl [NI];
    logic        er  [NI];
    logic [31:0] rd  [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .AW(32)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(v[0]), .req_write(w[0]), .req_addr(a[0]), .req_wdata(d[0]),
`ifdef DM_BYTE_EN
        .req_be(be[0]),
`endif
        .req_ready(rdy[0]), .rsp_valid(vld[0]), .rsp_rdata(rd[0]),
        .rsp_err(er[0]), .stall(stl[0])
    );

    dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .AW(32)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(v[1]), .req_write(w[1]), .req_addr(a[1]), .req_wdata(d[1]),
`ifdef DM_BYTE_EN
        .req_be(be[1]),
`endif
        .req_ready(rdy[1]), .rsp_valid(vld[1]), .rsp_rdata(rd[1]),
        .rsp_err(er[1]), .stall(stl[1])
    );

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding access, response W+1 cycles after acceptance.
    bit          busy    [NI];
    int          rsp_cyc [NI];
    bit          p_w     [NI];
    logic [31:0] p_a     [NI];
    logic [31:0] p_d     [NI];
    logic [3:0]  p_be    [NI];
    logic [31:0] mem     [NI][DEPTH];
    int          pulses  [NI];
    int          cyc = 0;

    always @(negedge clk) begin
        bit          e_rdy, e_vld, e_stl, e_err, ok;
        logic [31:0] e_rd;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (vld[i] === 1'b1) pulses[i]++;
            ok = 1'b0;
            if (reset) begin
                e_rdy = 1; e_vld = 0; e_stl = 0; e_err = 0; e_rd = 0;
                busy[i] = 0;
            end else begin
                e_rdy = !busy[i];
                e_vld = busy[i] && (cyc == rsp_cyc[i]);
                e_stl = (!busy[i] && v[i]) || (busy[i] && cyc < rsp_cyc[i]);
                e_err = 0;
                e_rd  = 0;
                if (e_vld) begin
                    ok    = (p_a[i][1:0] == 2'b00) && (p_a[i] < 32'(DEPTH * 4));
                    e_err = !ok;
                    if (ok && !p_w[i]) e_rd = mem[i][p_a[i][7:2]];
                    if (ok && p_w[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (p_be[i][b]) mem[i][p_a[i][7:2]][8*b +: 8] = p_d[i][8*b +: 8];
                    end
                end
            end
            chk($sformatf("i%0d req_ready", i), rdy[i], e_rdy);
            chk($sformatf("i%0d rsp_valid", i), vld[i], e_vld);
            chk($sformatf("i%0d stall", i), stl[i], e_stl);
            chk($sformatf("i%0d rsp_err", i), er[i], e_err);
            chk($sformatf("i%0d rsp_rdata", i), rd[i], e_rd);
            if (!reset) begin
                if (e_vld) begin
                    busy[i] = 0;
                end else if (!busy[i] && v[i]) begin
                    busy[i]    = 1;
                    rsp_cyc[i] = cyc + wc(i) + 1;
                    p_w[i]     = w[i];
                    p_a[i]     = a[i];
                    p_d[i]     = d[i];
`ifdef DM_BYTE_EN
                    p_be[i]    = be[i];
`else
                    p_be[i]    = 4'hF;
`endif
                end
            end
        end
    end

    task automatic do_txn(input int i, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] bev, input bit scramble,
                          output logic [31:0] rdo, output bit erro, output int lat);
        bit got;
        @(posedge clk); #1;
        v[i] = 1; w[i] = wr; a[i] = addr; d[i] = data; be[i] = bev;
        @(negedge clk);
        chk("accept ready", rdy[i], 1);
        @(posedge clk); #1;
        v[i] = 0;
        if (scramble) begin
            a[i] = addr ^ 32'h0000_000C;
            d[i] = ~data;
            w[i] = ~wr;
        end
        lat = 0; got = 0; rdo = 0; erro = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (vld[i] === 1'b1) begin
                got = 1; rdo = rd[i]; erro = er[i];
            end
        end
        chk("response seen", got, 1);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            1:       return 32'h100 + 32'($urandom_range(0, 100) * 4);
            2:       return $urandom();
            default: return 32'($urandom_range(0, 15) * 4);
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        bit          e;
        int          l, acc, p0;
        bit          rst_now;
        for (int i = 0; i < NI; i++) begin
            v[i] = 0; w[i] = 0; a[i] = 0; d[i] = 0; be[i] = 4'hF;
            busy[i] = 0; pulses[i] = 0;
            for (int k = 0; k < DEPTH; k++) mem[i][k] = 0;
        end
        #1 reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Bring both arrays to a known all-zero image.
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < DEPTH; k++)
                do_txn(i, 1, 32'(k * 4), 32'd0, 4'hF, 0, r, e, l);

        // Store then load with two wait states.
        do_txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, r, e, l);
        chk("t1 store latency", l, 3);
        chk("t1 store err", e, 0);
        do_txn(0, 0, 32'h10, 32'h0, 4'hF, 0, r, e, l);
        chk("t1 load data", r, 32'hDEADBEEF);
        chk("t1 load latency", l, 3);

        // Zero wait states: next-cycle response, one access every two cycles.
        do_txn(1, 0, 32'h0, 32'h0, 4'hF, 0, r, e, l);
        chk("t2 load data", r, 32'h0);
        chk("t2 load latency", l, 1);
        @(posedge clk); #1;
        v[1] = 1; w[1] = 0; a[1] = 32'h0;
        acc = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdy[1] === 1'b1) acc++;
        end
        @(posedge clk); #1;
        v[1] = 0;
        chk("t2 b2b accepts", acc, 3);

        // Error responses leave the array untouched.
        do_txn(0, 1, 32'h13, 32'hCAFEF00D, 4'hF, 0, r, e, l);
        chk("t3 misaligned err", e, 1);
        chk("t3 misaligned rdata", r, 0);
        do_txn(0, 0, 32'h10, 32'h0, 4'hF, 0, r, e, l);
        chk("t3 prior value", r, 32'hDEADBEEF);
        do_txn(0, 0, 32'h100, 32'h0, 4'hF, 0, r, e, l);
        chk("t3 range err", e, 1);
        chk("t3 range rdata", r, 0);

        // Reset during WAIT discards the captured store.
        @(posedge clk); #1;
        v[0] = 1; w[0] = 1; a[0] = 32'h20; d[0] = 32'h12345678;
        @(posedge clk); #1;
        v[0] = 0;
        reset = 1;
        #1;
        chk("t4 ready", rdy[0], 1);
        chk("t4 valid", vld[0], 0);
        chk("t4 stall", stl[0], 0);
        chk("t4 rdata", rd[0], 0);
        chk("t4 err", er[0], 0);
        @(posedge clk); #1;
        reset = 0;
        do_txn(0, 0, 32'h20, 32'h0, 4'hF, 0, r, e, l);
        chk("t4 old value", r, 32'h0);

        // Request changes during WAIT are ignored.
        do_txn(0, 1, 32'h04, 32'h55AA55AA, 4'hF, 0, r, e, l);
        do_txn(0, 1, 32'h08, 32'h00000066, 4'hF, 0, r, e, l);
        @(posedge clk); #2;
        p0 = pulses[0];
        do_txn(0, 0, 32'h04, 32'h0, 4'hF, 1, r, e, l);
        chk("t5 captured addr", r, 32'h55AA55AA);
        repeat (5) @(negedge clk);
        #1;
        chk("t5 pulse count", pulses[0] - p0, 1);

`ifdef DM_BYTE_EN
        do_txn(0, 1, 32'h08, 32'hAABBCCDD, 4'hF, 0, r, e, l);
        do_txn(0, 1, 32'h08, 32'h11223344, 4'b0101, 0, r, e, l);
        do_txn(0, 0, 32'h08, 32'h0, 4'b0000, 0, r, e, l);
        chk("t6 lane merge", r, 32'hAA22CC44);
        do_txn(0, 1, 32'h08, 32'hFFFFFFFF, 4'b0000, 0, r, e, l);
        chk("t6 be0 err", e, 0);
        do_txn(0, 0, 32'h08, 32'h0, 4'hF, 0, r, e, l);
        chk("t6 be0 unchanged", r, 32'hAA22CC44);
`endif

        // Random traffic, including occasional resets.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            rst_now = ($urandom_range(0, 299) == 0);
            reset = rst_now;
            for (int i = 0; i < NI; i++) begin
                v[i]  = rst_now ? 1'b0 : ($urandom_range(0, 2) != 0);
                w[i]  = 1'($urandom_range(0, 1));
                a[i]  = rand_addr();
                d[i]  = $urandom();
                be[i] = 4'($urandom_range(0, 15));
            end
        end
        @(posedge clk); #1;
        reset = 0;
        for (int i = 0; i < NI; i++) v[i] = 0;
        repeat (20) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
